// File: rtl/paint_scheduler.sv
// paint_scheduler: round-robin arbiter that shares one bar-painting unit
// between NREQ weight-display requesters. Each grant issues one print pulse,
// follows the painter's stat window until the bar ends (or hangs), acks the
// requester and then holds off for GAP idle cycles before the next grant.
module paint_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    parameter int GAP     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         ack,
    output logic                    print,
    input  logic                    stat,
    input  logic                    clr_err,
    output logic [$clog2(NREQ)-1:0] active_id,
    output logic                    busy,
    output logic                    err
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        PAINT,
        GAP_WAIT
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [TW-1:0]   timer;
    logic [GW-1:0]   gapcnt;
    logic [IW-1:0]   grant;
    logic            found;
    logic [NREQ-1:0] onehot;

    // Pick the first pending requester after the last one served, wrapping around.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && req[IW'((int'(ptr) + i) % NREQ)]) begin
                found = 1'b1;
                grant = IW'((int'(ptr) + i) % NREQ);
            end
        end
    end

    // Ack vector for the requester currently being served.
    always_comb begin
        onehot = NREQ'(1) << active_id;
    end

    // Scheduler FSM; every output is a register so the painter and requesters see clean pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ack       <= '0;
            print     <= 1'b0;
            active_id <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
            ptr       <= IW'(NREQ - 1);
            timer     <= '0;
            gapcnt    <= '0;
        end else begin
            ack   <= '0;
            print <= 1'b0;
            // A timeout later in this block overrides the clear, so a
            // simultaneous clear and timeout leaves err set.
            if (clr_err) begin
                err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (found) begin
                        active_id <= grant;
                        ptr       <= grant;
                        print     <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT_START;
                end
                WAIT_START: begin
                    if (stat) begin
                        timer <= '0;
                        state <= PAINT;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        err    <= 1'b1;
                        ack    <= onehot;
                        gapcnt <= '0;
                        state  <= GAP_WAIT;
                    end else if (timer != TW'(TIMEOUT)) begin
                        timer <= timer + TW'(1);
                    end
                end
                PAINT: begin
                    if (!stat) begin
                        ack    <= onehot;
                        gapcnt <= '0;
                        state  <= GAP_WAIT;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        err    <= 1'b1;
                        ack    <= onehot;
                        gapcnt <= '0;
                        state  <= GAP_WAIT;
                    end else if (timer != TW'(TIMEOUT)) begin
                        timer <= timer + TW'(1);
                    end
                end
                GAP_WAIT: begin
                    if (gapcnt == GW'(GAP - 1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gapcnt <= gapcnt + GW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_paint_scheduler.sv
// tb_paint_scheduler: drives requester patterns and a behavioural painter into
// paint_scheduler and predicts every output from event-level timing rules and
// a round-robin pick over the requested set.
module tb_paint_scheduler;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam int GAP     = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] ack;
    logic       print;
    logic       stat;
    logic       clr_err;
    logic [1:0] active_id;
    logic       busy;
    logic       err;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   ptrModel;
    logic errModel;

    paint_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .ack       (ack),
        .print     (print),
        .stat      (stat),
        .clr_err   (clr_err),
        .active_id (active_id),
        .busy      (busy),
        .err       (err)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int rrPick(input logic [3:0] pattern, input int last);
        for (int i = 1; i <= NREQ; i++) begin
            if (pattern[(last + i) % NREQ]) return (last + i) % NREQ;
        end
        return -1;
    endfunction

    // One full service starting from an idle cycle: the painter stays quiet for
    // d cycles after the print, then holds stat for L cycles.
    task automatic applyStimulus(input logic [3:0] pattern, input int d, input int L,
                                 input int dropMode, input bit clrAtAbort);
        int         g;
        int         t0;
        int         ackCyc;
        int         rel;
        bit         abort;
        bit         clrNow;
        logic [3:0] onehot;
        req     = pattern;
        stat    = 1'b0;
        clr_err = 1'b0;
        g        = rrPick(pattern, ptrModel);
        ptrModel = g;
        onehot   = 4'(1 << g);
        t0       = cyc + 1;
        if (d >= TIMEOUT) begin
            abort  = 1'b1;
            ackCyc = t0 + 1 + TIMEOUT;
        end else if (L - 1 >= TIMEOUT) begin
            abort  = 1'b1;
            ackCyc = t0 + 2 + d + TIMEOUT;
        end else begin
            abort  = 1'b0;
            ackCyc = t0 + 2 + d + L;
        end
        clrNow = 1'b0;
        while (cyc < ackCyc + GAP) begin
            step();
            if (clrNow) errModel = 1'b0;
            if (abort && cyc == ackCyc) errModel = 1'b1;
            checkOutput("print", 32'(print), 32'(cyc == t0));
            checkOutput("ack", 32'(ack), 32'((cyc == ackCyc) ? onehot : 4'b0000));
            checkOutput("busy", 32'(busy), 32'(cyc < ackCyc + GAP));
            checkOutput("err", 32'(err), 32'(errModel));
            if (cyc < ackCyc + GAP) checkOutput("active_id", 32'(active_id), 32'(g));
            rel     = cyc - (t0 + 1);
            stat    = (rel >= d) && (rel < d + L);
            clrNow  = clrAtAbort && abort && (cyc == ackCyc - 1);
            clr_err = clrNow;
            if (dropMode != 0 && cyc == t0 + 2) req = (dropMode == 1) ? 4'b0000 : 4'($urandom);
        end
        clr_err = 1'b0;
    endtask

    // Idle cycles with no requests; optional spurious stat must be ignored.
    task automatic idleCycles(input int n, input bit spurious);
        req = 4'b0000;
        for (int i = 0; i < n; i++) begin
            stat = spurious ? 1'($urandom) : 1'b0;
            step();
            checkOutput("idle_print", 32'(print), 32'(0));
            checkOutput("idle_busy", 32'(busy), 32'(0));
            checkOutput("idle_ack", 32'(ack), 32'(0));
        end
        stat = 1'b0;
    endtask

    task automatic clearErr();
        req     = 4'b0000;
        clr_err = 1'b1;
        step();
        clr_err  = 1'b0;
        errModel = 1'b0;
        checkOutput("err_clear", 32'(err), 32'(0));
        checkOutput("clear_busy", 32'(busy), 32'(0));
    endtask

    // Grant requester 2, let it start painting, then reset asynchronously mid-bar.
    task automatic resetMidPaint();
        req  = 4'b0100;
        stat = 1'b0;
        step();
        checkOutput("rst_pre_print", 32'(print), 32'(1));
        stat = 1'b1;
        repeat (3) step();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_async_busy", 32'(busy), 32'(0));
        checkOutput("rst_async_print", 32'(print), 32'(0));
        checkOutput("rst_async_ack", 32'(ack), 32'(0));
        checkOutput("rst_async_err", 32'(err), 32'(0));
        checkOutput("rst_async_id", 32'(active_id), 32'(0));
        step();
        checkOutput("rst_hold_ack", 32'(ack), 32'(0));
        checkOutput("rst_hold_busy", 32'(busy), 32'(0));
        reset    = 1'b0;
        stat     = 1'b0;
        ptrModel = NREQ - 1;
        errModel = 1'b0;
    endtask

    // Directed scenarios followed by a randomized run.
    initial begin
        reset   = 1'b1;
        req     = 4'b0000;
        stat    = 1'b0;
        clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ack", 32'(ack), 32'(0));
        checkOutput("reset_print", 32'(print), 32'(0));
        checkOutput("reset_busy", 32'(busy), 32'(0));
        checkOutput("reset_err", 32'(err), 32'(0));
        checkOutput("reset_id", 32'(active_id), 32'(0));
        reset    = 1'b0;
        ptrModel = NREQ - 1;
        errModel = 1'b0;

        applyStimulus(4'b0001, 2, 30, 0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(4'b1111, 0, 5, 0, 1'b0);
        applyStimulus(4'b0010, TIMEOUT + 10, 1, 0, 1'b0);
        clearErr();
        applyStimulus(4'b1000, 1, 1000, 0, 1'b0);
        applyStimulus(4'b0001, 0, 3, 0, 1'b0);
        applyStimulus(4'b0100, TIMEOUT - 1, 3, 0, 1'b0);
        applyStimulus(4'b0100, TIMEOUT, 3, 0, 1'b1);
        applyStimulus(4'b0010, 0, TIMEOUT, 0, 1'b0);
        applyStimulus(4'b0010, 0, TIMEOUT + 1, 0, 1'b0);
        clearErr();
        resetMidPaint();
        applyStimulus(4'b0101, 1, 4, 0, 1'b0);
        applyStimulus(4'b0101, 1, 4, 0, 1'b0);
        applyStimulus(4'b0010, 1, 10, 1, 1'b0);
        idleCycles(4, 1'b1);

        for (int n = 0; n < 40; n++) begin
            int sel;
            int d;
            int L;
            sel = int'($urandom % 10);
            d   = (sel == 0) ? TIMEOUT + int'($urandom % 4) : int'($urandom % 4);
            L   = (sel == 1) ? TIMEOUT + 1 + int'($urandom % 3) : 1 + int'($urandom % 40);
            applyStimulus(4'($urandom_range(1, 15)), d, L, int'($urandom % 3), 1'($urandom));
            if ($urandom % 3 == 0) idleCycles(int'($urandom_range(1, 3)), 1'b1);
            if (errModel && ($urandom % 2 == 0)) clearErr();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
